// File: rtl/seg7_scan3.sv
// seg7_scan3: three-digit multiplexed driver for a common-anode 7-segment display.
// Ports: clk, rst_n (async low); load + numb1..3 (BCD units/tens/hundreds) in;
//   seg (active-low {g..a}), an (active-low, bit0=units), frame_done out.
module seg7_scan3 #(
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYC    = 4,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] numb1,
   input  logic [3:0] numb2,
   input  logic [3:0] numb3,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame_done
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] P_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] DEAD  = PW'(DEAD_CYC);

   logic [PW-1:0] p;
   logic [1:0]    i;
   logic [11:0]   shadow;
   logic [11:0]   disp;
   logic          p_wrap;
   logic          f_wrap;
   logic [3:0]    digit;
   logic          blank;
   logic [6:0]    seg_n;
   logic [2:0]    an_n;

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign p_wrap = (p == P_MAX);
   assign f_wrap = p_wrap && (i == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p      <= '0;
         i      <= 2'd0;
         shadow <= '0;
         disp   <= '0;
      end else begin
         p <= p_wrap ? '0 : p + 1'b1;
         if (p_wrap)
            i <= (i == 2'd2) ? 2'd0 : i + 2'd1;
         if (load)
            shadow <= {numb3, numb2, numb1};
         // Commit at frame wrap; a load on that very cycle bypasses the shadow.
         if (f_wrap)
            disp <= load ? {numb3, numb2, numb1} : shadow;
      end
   end

   always_comb begin
      digit = disp[3:0];
      blank = 1'b0;
      seg_n = 7'b1111111;
      an_n  = 3'b111;
      case (i)
         2'd1:    digit = disp[7:4];
         2'd2:    digit = disp[11:8];
         default: digit = disp[3:0];
      endcase
      // Dash codes (10-15) are non-zero, so they never trigger blanking.
      if (BLANK_LZ) begin
         case (i)
            2'd2:    blank = (disp[11:8] == 4'd0);
            2'd1:    blank = (disp[11:8] == 4'd0) && (disp[7:4] == 4'd0);
            default: blank = 1'b0;
         endcase
      end
      if ((p >= DEAD) && !blank) begin
         an_n  = ~(3'b001 << i);
         seg_n = enc(digit);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= 7'b1111111;
         an         <= 3'b111;
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_n;
         an         <= an_n;
         frame_done <= f_wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan3.sv
// tb_seg7_scan3: scoreboard bench for seg7_scan3 (REFRESH_DIV=8, DEAD_CYC=2).
// Two instances share stimulus: leading-zero blanking on (dut) and off (dut0).
module tb_seg7_scan3;

   localparam int RD = 8;
   localparam int DC = 2;
   localparam int FR = 3 * RD;
   localparam int BIG = 1000000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load = 1'b0;
   logic [3:0] n1 = 4'd0;
   logic [3:0] n2 = 4'd0;
   logic [3:0] n3 = 4'd0;
   logic [6:0] seg, seg0;
   logic [2:0] an, an0;
   logic       fd, fd0;

   seg7_scan3 #(.REFRESH_DIV(RD), .DEAD_CYC(DC), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .load(load),
      .numb1(n1), .numb2(n2), .numb3(n3),
      .seg(seg), .an(an), .frame_done(fd)
   );

   seg7_scan3 #(.REFRESH_DIV(RD), .DEAD_CYC(DC), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load),
      .numb1(n1), .numb2(n2), .numb3(n3),
      .seg(seg0), .an(an0), .frame_done(fd0)
   );

   always #5 clk = ~clk;

   // Cycle n = output after the n-th rising edge since reset release.
   int cyc = 0;
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   typedef struct {
      int         c;
      bit         alt;
      logic [6:0] s;
      logic [2:0] a;
      logic       f;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic push(input int c, input bit alt,
                       input logic [6:0] s, input logic [2:0] a,
                       input logic f);
      exp_t e;
      e.c = c; e.alt = alt; e.s = s; e.a = a; e.f = f;
      q.push_back(e);
   endtask

   // Expected outputs for display frame f; a slot code of 7F means blanked.
   task automatic push_frame(input int f, input int last,
                             input logic [6:0] u, input logic [6:0] t,
                             input logic [6:0] h, input logic [6:0] u0,
                             input logic [6:0] t0, input logic [6:0] h0);
      for (int m = 0; m < FR; m++) begin
         automatic int n = FR * f + 1 + m;
         automatic int sl = m / RD;
         automatic int pp = m % RD;
         automatic logic fe = (m == FR - 1);
         if (n <= last) begin
            for (int k = 0; k < 2; k++) begin
               automatic logic [6:0] sv;
               sv = (sl == 0) ? ((k == 0) ? u : u0) :
                    (sl == 1) ? ((k == 0) ? t : t0) :
                                ((k == 0) ? h : h0);
               if (pp < DC || sv == 7'h7F)
                  push(n, k[0], 7'h7F, 3'b111, fe);
               else
                  push(n, k[0], sv, ~(3'b001 << sl), fe);
            end
         end
      end
   endtask

   task automatic check(input exp_t e);
      logic [6:0] s;
      logic [2:0] a;
      logic       f;
      s = e.alt ? seg0 : seg;
      a = e.alt ? an0 : an;
      f = e.alt ? fd0 : fd;
      n_chk++;
      if (s !== e.s || a !== e.a || f !== e.f) begin
         n_fail++;
         $display("FAIL %s cyc%0d rst_n=%b: seg=%b an=%b fd=%b, want seg=%b an=%b fd=%b",
                  e.alt ? "lz0" : "lz1", e.c, rst_n, s, a, f, e.s, e.a, e.f);
      end
   endtask

   always @(negedge clk) begin
      while (q.size() > 0) begin
         if (!rst_n ? (q[0].c == 0) : (q[0].c == cyc)) begin
            check(q.pop_front());
         end else if (rst_n && q[0].c != 0 && q[0].c < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed cyc%0d at cyc%0d", q[0].c, cyc);
            void'(q.pop_front());
         end else begin
            break;
         end
      end
   end

   task automatic at_cycle(input int n);
      while (cyc != n) @(negedge clk);
   endtask

   // Present digits so the rising edge that ends cycle e-1 captures them.
   task automatic do_load(input int e, input logic [3:0] h,
                          input logic [3:0] t, input logic [3:0] u);
      at_cycle(e - 1);
      n3 = h; n2 = t; n1 = u;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n3 = 4'd8; n2 = 4'd8; n1 = 4'd8;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      push(0, 1'b0, 7'h7F, 3'b111, 1'b0);
      push(0, 1'b1, 7'h7F, 3'b111, 1'b0);
      push_frame(0, BIG, 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
      push_frame(1, BIG, 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
      push_frame(2, BIG, 7'h30, 7'h24, 7'h79, 7'h30, 7'h24, 7'h79);
      push_frame(3, BIG, 7'h78, 7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40);
      push_frame(4, BIG, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);
      push_frame(5, BIG, 7'h12, 7'h3F, 7'h7F, 7'h12, 7'h3F, 7'h40);
      push_frame(6, 156, 7'h12, 7'h3F, 7'h7F, 7'h12, 7'h3F, 7'h40);
      push(0, 1'b0, 7'h7F, 3'b111, 1'b0);
      push(0, 1'b1, 7'h7F, 3'b111, 1'b0);
      push_frame(0, BIG, 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);
      push_frame(1, BIG, 7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40);

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      do_load(30, 4'd1, 4'd2, 4'd3);
      do_load(55, 4'd0, 4'd0, 4'd7);
      do_load(80, 4'd4, 4'd5, 4'd6);
      do_load(96, 4'd9, 4'd9, 4'd9);
      do_load(100, 4'd1, 4'd1, 4'd1);
      do_load(104, 4'd0, 4'd12, 4'd5);

      at_cycle(156);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      at_cycle(50);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending=%0d, want 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
